alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_multicycle.sv | 123 ++++++++++++
 tb/tb_alu_multicycle.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and control-FSM state encoding for the multicycle ALU.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b1000;
   localparam logic [OP_W-1:0] OP_SLTU = 4'b1001;
   localparam logic [OP_W-1:0] OP_MUL  = 4'b1010;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
   localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles, low WIDTH bits kept.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic             busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
         end else if (busy) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            // Last of WIDTH iterations: flag completion one cycle later
            if (cnt == CNT_W'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Valid/ready ALU: single-cycle logic/arith/shift ops, optional iterative multiply via control FSM.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_EN  = 1,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               ovf
);

   state_t           state;
   logic             accept;
   logic             is_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);
   assign sum      = a + b;
   assign diff     = a - b;

   // Single-cycle datapath; undefined opcodes (and MUL without a multiplier) yield 0
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: alu_res = WIDTH'(a < b);
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (accept && is_mul),
            .a       (a),
            .b       (b),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // Control FSM with registered result/flags/valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= S_MUL;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     ovf       <= alu_ovf;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (mul_done) begin
                  result    <= mul_product;
                  zero      <= (mul_product == '0);
                  ovf       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_valid && out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32), plus a MUL-less instance on shared inputs.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned SW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [3:0]    op = 4'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [SW-1:0] shamt = '0;

   logic          in_ready, out_valid, zero, ovf;
   logic [W-1:0]  result;
   logic          nm_in_ready, nm_out_valid, nm_zero, nm_ovf;
   logic [W-1:0]  nm_result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .ovf(ovf)
   );

   alu_multicycle #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nm_in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt),
      .out_valid(nm_out_valid), .out_ready(out_ready),
      .result(nm_result), .zero(nm_zero), .ovf(nm_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [SW-1:0] s);
      @(negedge clk);
      op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [W-1:0] r, input logic z, input logic v);
      chk({tag, ".valid"}, 64'(out_valid), 64'(1));
      chk({tag, ".result"}, 64'(result), 64'(r));
      chk({tag, ".zero"}, 64'(zero), 64'(z));
      chk({tag, ".ovf"}, 64'(ovf), 64'(v));
   endtask

   initial begin
      int  cyc;
      logic flag;

      // Reset state
      #12;
      chk("rst.valid", 64'(out_valid), 64'(0));
      chk("rst.result", 64'(result), 64'(0));
      chk("rst.zero", 64'(zero), 64'(0));
      chk("rst.ovf", 64'(ovf), 64'(0));
      chk("rst.in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle ops issued back-to-back
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, '0);
      expect_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
      issue(OP_SUB, 32'd5, 32'd5, '0);
      expect_res("sub_zero", 32'h0, 1'b1, 1'b0);
      issue(OP_SUB, 32'h8000_0000, 32'h1, '0);
      expect_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
      issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, '0);
      expect_res("add_wrap", 32'h0, 1'b1, 1'b0);
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, '0);
      expect_res("slt", 32'h1, 1'b0, 1'b0);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, '0);
      expect_res("sltu", 32'h0, 1'b1, 1'b0);
      issue(OP_SRA, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      expect_res("sra", 32'hF800_0000, 1'b0, 1'b0);
      issue(OP_SRL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      expect_res("srl", 32'h0800_0000, 1'b0, 1'b0);
      issue(OP_SLL, 32'h1, 32'h0, 5'd31);
      expect_res("sll", 32'h8000_0000, 1'b0, 1'b0);
      issue(OP_NOR, 32'h0, 32'h0, '0);
      expect_res("nor", 32'hFFFF_FFFF, 1'b0, 1'b0);
      issue(OP_XOR, 32'hF0, 32'h3C, '0);
      expect_res("xor", 32'hCC, 1'b0, 1'b0);
      issue(OP_OR, 32'hF0, 32'h3C, '0);
      expect_res("or", 32'hFC, 1'b0, 1'b0);
      issue(4'b1111, 32'h1234, 32'h5678, '0);
      expect_res("undef", 32'h0, 1'b1, 1'b0);

      // MUL: WIDTH+1 cycle latency, in_ready low throughout
      issue(OP_MUL, 32'h0001_0001, 32'h0001_0001, '0);
      chk("mul.valid_after_accept", 64'(out_valid), 64'(0));
      chk("nomul.valid", 64'(nm_out_valid), 64'(1));
      chk("nomul.result", 64'(nm_result), 64'(0));
      chk("nomul.zero", 64'(nm_zero), 64'(1));
      chk("nomul.ovf", 64'(nm_ovf), 64'(0));
      chk("nomul.in_ready", 64'(nm_in_ready), 64'(1));
      cyc = 0;
      flag = 1'b0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) flag = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("mul.in_ready_low", 64'(flag), 64'(0));
      chk("mul.latency", 64'(cyc), 64'(33));
      expect_res("mul", 32'h0002_0001, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("mul.drop_valid", 64'(out_valid), 64'(0));
      chk("mul.back_idle", 64'(in_ready), 64'(1));

      // Backpressure: result held, pending request ignored until release
      out_ready = 1'b0;
      issue(OP_AND, 32'hF0, 32'h3C, '0);
      expect_res("and", 32'h30, 1'b0, 1'b0);
      op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
      flag = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (!out_valid || result !== 32'h30 || in_ready) flag = 1'b1;
      end
      chk("stall.hold", 64'(flag), 64'(0));
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("stall.release_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_res("stall.next_add", 32'h3, 1'b0, 1'b0);

      // Reset during MUL iteration 10 abandons the operation
      issue(OP_MUL, 32'd3, 32'd5, '0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmul.valid", 64'(out_valid), 64'(0));
      chk("rstmul.result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      flag = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) flag = 1'b1;
      end
      chk("rstmul.no_stale", 64'(flag), 64'(0));
      chk("rstmul.in_ready", 64'(in_ready), 64'(1));
      issue(4'b1111, 32'hFFFF, 32'hFFFF, '0);
      expect_res("rstmul.undef", 32'h0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
